seq_detector_param: RTL and testbench

Parametrised Mealy serial-sequence detector, the successor of the lab's fixed-pattern single-bit `mealy` detector. It watches a 1-bit serial input and asserts a same-cycle Mealy output when the last `pat_len` bits equal a runtime-loadable pattern, supporting patterns up to `N` bits. It selects overlapping or non-overlapping detection and keeps a saturating match counter. It sits between the board's debounced serial input and the LED/seven-segment display logic.

---
 rtl/seq_det_pkg.sv | 37 +++
 rtl/seq_det_next.sv | 36 +++
 rtl/seq_detector_param.sv | 77 +++++++
 tb/tb_seq_detector_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared widths and the KMP fallback function for the serial sequence detector.
package seq_det_pkg;

  // Largest pattern the fallback function handles; module N must not exceed it.
  localparam int N_MAX   = 32;
  localparam int STATE_W = $clog2(N_MAX);
  localparam int LEN_W   = $clog2(N_MAX + 1);

  // Longest prefix (shorter than len) that ends the history "first s pattern
  // bits followed by b". Expected bit j (1-based) lives at pat[len-j].
  // Called with s = len-1 and b = pat[0] it yields the longest proper border.
  function automatic logic [STATE_W-1:0] border_len(
    input logic [N_MAX-1:0] pat,
    input logic [LEN_W-1:0] len,
    input logic [STATE_W-1:0] s,
    input logic b
  );
    int l;
    int sv;
    int best;
    logic ok;
    l    = int'(len);
    sv   = int'(s);
    best = 0;
    for (int k = 1; k < N_MAX; k++) begin
      if (k < l && k <= sv + 1) begin
        ok = (pat[l - k] == b);
        for (int j = 1; j < N_MAX; j++) begin
          if (j < k && pat[l - j] != pat[l - (sv - k + 1 + j)]) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return STATE_W'(best);
  endfunction

endpackage

// File: rtl/seq_det_next.sv
// Combinational next-state logic: KMP fallback, match detection and
// overlap / restart selection after a full match.
module seq_det_next
  import seq_det_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]           pat,
  input  logic [$clog2(N+1)-1:0] len,
  input  logic [$clog2(N)-1:0]   state,
  input  logic                   in,
  input  logic                   overlap,
  output logic [$clog2(N)-1:0]   next_state,
  output logic                   hit
);

  localparam int SW = $clog2(N);

  logic [N_MAX-1:0]   pat_ext;
  logic [STATE_W-1:0] fb;

  // A match reuses the same fallback: at state len-1 with the final bit the
  // longest prefix below len is exactly the pattern's proper border.
  always_comb begin
    pat_ext         = '0;
    pat_ext[N-1:0]  = pat;
    fb              = border_len(pat_ext, LEN_W'(len), STATE_W'(state), in);
    hit             = (len != '0) && (int'(state) == int'(len) - 1) && (in == pat[0]);
    next_state      = '0;
    if (len != '0) begin
      if (hit) next_state = overlap ? SW'(fb) : '0;
      else     next_state = SW'(fb);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-sequence detector with runtime-loadable pattern,
// overlap selection and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int           N       = 8,
  parameter int           DEF_LEN = 5,
  parameter logic [N-1:0] PATTERN = N'(8'b0001_1011),
  parameter int           CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in,
  input  logic                   en,
  input  logic                   overlap,
  input  logic                   pat_load,
  input  logic [N-1:0]           pat_in,
  input  logic [$clog2(N+1)-1:0] pat_len,
  input  logic                   cnt_clr,
  output logic                   out,
  output logic [$clog2(N)-1:0]   state,
  output logic [CNT_W-1:0]       match_cnt
);

  localparam int LW = $clog2(N + 1);
  localparam int SW = $clog2(N);
  localparam logic [LW-1:0]    LEN_MAX  = LW'(N);
  localparam logic [LW-1:0]    LEN_RST  = LW'(DEF_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  logic [N-1:0]  pat;
  logic [LW-1:0] len;
  logic [LW-1:0] load_len;
  logic [SW-1:0] next_state;
  logic          hit;

  seq_det_next #(.N(N)) u_next (
    .pat        (pat),
    .len        (len),
    .state      (state),
    .in         (in),
    .overlap    (overlap),
    .next_state (next_state),
    .hit        (hit)
  );

  assign load_len = (pat_len > LEN_MAX) ? LEN_MAX : pat_len;

  // Zero-latency Mealy output; a load cycle discards the sampled bit.
  assign out = rst_n & en & ~pat_load & hit;

  // Pattern and length registers, reloaded on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat <= PATTERN;
      len <= LEN_RST;
    end else if (pat_load) begin
      pat <= pat_in;
      len <= load_len;
    end
  end

  // Matched-prefix state; a load restarts matching, en=0 freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        state <= '0;
    else if (pat_load) state <= '0;
    else if (en)       state <= next_state;
  end

  // Saturating match counter; clear wins over a simultaneous match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          match_cnt <= '0;
    else if (cnt_clr)                    match_cnt <= '0;
    else if (out && match_cnt != CNT_SAT) match_cnt <= match_cnt + 1'b1;
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: inputs change 3 ns after the rising
// edge, out is sampled mid-period, registered outputs 1 ns after the edge.
module tb_seq_detector_param;

  localparam int N     = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in;
  logic             en;
  logic             overlap;
  logic             pat_load;
  logic [N-1:0]     pat_in;
  logic [3:0]       pat_len;
  logic             cnt_clr;
  logic             out;
  logic [2:0]       state;
  logic [CNT_W-1:0] match_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.N(N), .DEF_LEN(5), .PATTERN(8'b0001_1011), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .en        (en),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .pat_len   (pat_len),
    .cnt_clr   (cnt_clr),
    .out       (out),
    .state     (state),
    .match_cnt (match_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Called at edge+3: drive bit, check out mid-period, check state after edge.
  task automatic step(input string tag, input logic b, input logic exp_out, input int exp_state);
    in = b;
    #2;
    check({tag, ".out"}, 32'(out), 32'(exp_out));
    @(posedge clk);
    #1;
    check({tag, ".state"}, 32'(state), exp_state);
    #2;
  endtask

  // Asynchronous reset pulse mid-period; state and count must clear at once.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, ".rst_state"}, 32'(state), 0);
    check({tag, ".rst_cnt"}, 32'(match_cnt), 0);
    check({tag, ".rst_out"}, 32'(out), 0);
    en    = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #3;
    en = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in       = 1'b0;
    en       = 1'b0;
    overlap  = 1'b1;
    pat_load = 1'b0;
    pat_in   = '0;
    pat_len  = '0;
    cnt_clr  = 1'b0;
    #12;
    check("reset.out", 32'(out), 0);
    check("reset.state", 32'(state), 0);
    check("reset.cnt", 32'(match_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #3;
    en = 1'b1;

    // Default "11011", overlapping
    step("ov1", 1, 0, 1);
    step("ov2", 1, 0, 2);
    step("ov3", 0, 0, 3);
    step("ov4", 1, 0, 4);
    step("ov5", 1, 1, 2);
    check("ov5.cnt", 32'(match_cnt), 1);
    step("ov6", 0, 0, 3);
    step("ov7", 1, 0, 4);
    step("ov8", 1, 1, 2);
    check("ov8.cnt", 32'(match_cnt), 2);

    // Same stream, non-overlapping
    do_reset("t2");
    overlap = 1'b0;
    step("no1", 1, 0, 1);
    step("no2", 1, 0, 2);
    step("no3", 0, 0, 3);
    step("no4", 1, 0, 4);
    step("no5", 1, 1, 0);
    step("no6", 0, 0, 0);
    step("no7", 1, 0, 1);
    step("no8", 1, 0, 2);
    check("no.cnt", 32'(match_cnt), 1);

    // KMP fallback: third 1 keeps state at 2
    do_reset("t3");
    overlap = 1'b1;
    step("fb1", 1, 0, 1);
    step("fb2", 1, 0, 2);
    step("fb3", 1, 0, 2);
    step("fb4", 0, 0, 3);
    step("fb5", 1, 0, 4);
    step("fb6", 1, 1, 2);
    check("fb.cnt", 32'(match_cnt), 1);

    // Mid-stream load of "101" on a cycle that would otherwise match
    step("pre1", 0, 0, 3);
    step("pre2", 1, 0, 4);
    pat_load = 1'b1;
    pat_in   = 8'b0000_0101;
    pat_len  = 4'd3;
    step("load", 1, 0, 0);
    pat_load = 1'b0;
    check("load.cnt", 32'(match_cnt), 1);
    step("p1", 1, 0, 1);
    step("p2", 0, 0, 2);
    step("p3", 1, 1, 1);
    step("p4", 0, 0, 2);
    step("p5", 1, 1, 1);
    check("p.cnt", 32'(match_cnt), 3);

    // Reset restores default pattern; enable gating freezes a partial match
    do_reset("t5");
    step("g1", 1, 0, 1);
    step("g2", 1, 0, 2);
    step("g3", 0, 0, 3);
    step("g4", 1, 0, 4);
    en = 1'b0;
    step("gh1", 1, 0, 4);
    step("gh2", 1, 0, 4);
    en = 1'b1;
    step("g5", 1, 1, 2);
    check("g.cnt", 32'(match_cnt), 1);
    step("g6", 0, 0, 3);
    do_reset("t5mid");

    // Counter saturation with a one-bit pattern "1"
    pat_load = 1'b1;
    pat_in   = 8'b0000_0001;
    pat_len  = 4'd1;
    step("ld1", 0, 0, 0);
    pat_load = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step("sat", 1, 1, 0);
      check("sat.cnt", 32'(match_cnt), (i > 3) ? 3 : i);
    end
    cnt_clr = 1'b1;
    step("clr", 1, 1, 0);
    cnt_clr = 1'b0;
    check("clr.cnt", 32'(match_cnt), 0);
    step("aclr", 1, 1, 0);
    check("aclr.cnt", 32'(match_cnt), 1);

    // Oversized length clamps to N: eight ones, border of 11111111 is 7
    pat_load = 1'b1;
    pat_in   = 8'b1111_1111;
    pat_len  = 4'd15;
    step("ldclamp", 0, 0, 0);
    pat_load = 1'b0;
    for (int i = 1; i <= 7; i++) step("clamp", 1, 0, i);
    step("clamp8", 1, 1, 7);
    check("clamp.cnt", 32'(match_cnt), 2);

    // Zero length: detector idle
    pat_load = 1'b1;
    pat_len  = 4'd0;
    step("ld0", 1, 0, 0);
    pat_load = 1'b0;
    step("z1", 1, 0, 0);
    step("z2", 0, 0, 0);
    step("z3", 1, 0, 0);
    step("z4", 1, 0, 0);
    check("z.cnt", 32'(match_cnt), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
